writeback_stage: RTL and testbench

- Final pipeline stage, directly upstream of the 64x32 register file.
- Accepts completed results from the memory stage over a valid/ready handshake.
- Extracts and extends load data, and sequences 64-bit double results into two consecutive 32-bit register writes.
- Drives the register file write port (regwe, Rw, Din) from registered outputs.

---
 rtl/writeback_stage_if.sv | 26 ++
 rtl/writeback_stage.sv | 111 +++++++++++
 tb/tb_writeback_stage.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_if.sv
// Result handshake between the memory stage (master) and the writeback stage (slave).
// in_data uses big-endian bit numbering: in_data[0:DW-1] is the high/only word.
interface writeback_stage_if #(
    parameter int DW = 32,
    parameter int AW = 6
) ();
    logic            in_valid;
    logic            in_ready;
    logic [AW-1:0]   in_rd;
    logic [0:2*DW-1] in_data;
    logic            in_dbl;
    logic            in_load;
    logic [1:0]      in_ldsize;
    logic            in_ldsigned;
    logic [1:0]      in_byteoff;

    modport master (
        output in_valid, in_rd, in_data, in_dbl, in_load, in_ldsize, in_ldsigned, in_byteoff,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_rd, in_data, in_dbl, in_load, in_ldsize, in_ldsigned, in_byteoff,
        output in_ready
    );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: load extraction, double-result sequencing, registered register-file write port.
// Optional WB_R0_PROTECT_EN suppresses every register-file write addressed to register 0.
module writeback_stage #(
    parameter int DW = 32,
    parameter int AW = 6
) (
    input  logic               clk,
    input  logic               reset,
    writeback_stage_if.slave   in_if,
    output logic               regwe,
    output logic [AW-1:0]      Rw,
    output logic [DW-1:0]      Din,
    output logic               dbl_pending
);

    typedef enum logic {IDLE, DBL2} state_t;

    state_t        state_q, state_d;
    logic          regwe_q, regwe_d;
    logic [AW-1:0] rw_q, rw_d;
    logic [DW-1:0] din_q, din_d;
    logic [DW-1:0] lo_q, lo_d;
    logic          wr_en;

    // Byte offset 0 is the most significant byte; sub-word results are right-aligned.
    function automatic logic [DW-1:0] extract_load(input logic [0:DW-1] w,
                                                   input logic [1:0]    size,
                                                   input logic          sgn,
                                                   input logic [1:0]    off);
        logic [7:0]    b;
        logic [15:0]   h;
        logic [DW-1:0] r;
        case (off)
            2'd0:    b = w[0:7];
            2'd1:    b = w[8:15];
            2'd2:    b = w[16:23];
            default: b = w[24:31];
        endcase
        h = off[1] ? w[16:31] : w[0:15];
        case (size)
            2'b00:   r = {{(DW-8){sgn & b[7]}}, b};
            2'b01:   r = {{(DW-16){sgn & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            regwe_q <= 1'b0;
            rw_q    <= '0;
            din_q   <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            regwe_q <= regwe_d;
            rw_q    <= rw_d;
            din_q   <= din_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        rw_d    = rw_q;
        din_d   = din_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (in_if.in_valid) begin
                    wr_en = 1'b1;
                    if (in_if.in_load) begin
                        rw_d  = in_if.in_rd;
                        din_d = extract_load(in_if.in_data[0:DW-1], in_if.in_ldsize,
                                             in_if.in_ldsigned, in_if.in_byteoff);
                    end else if (in_if.in_dbl) begin
                        // Odd destinations are coerced onto the even/odd pair.
                        rw_d    = {in_if.in_rd[AW-1:1], 1'b0};
                        din_d   = in_if.in_data[0:DW-1];
                        lo_d    = in_if.in_data[DW:2*DW-1];
                        state_d = DBL2;
                    end else begin
                        rw_d  = in_if.in_rd;
                        din_d = in_if.in_data[0:DW-1];
                    end
                end
            end
            DBL2: begin
                wr_en   = 1'b1;
                rw_d    = {rw_q[AW-1:1], 1'b1};
                din_d   = lo_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef WB_R0_PROTECT_EN
        regwe_d = wr_en && (rw_d != '0);
`else
        regwe_d = wr_en;
`endif
    end

    assign in_if.in_ready = (state_q == IDLE);
    assign dbl_pending    = (state_q == DBL2);
    assign regwe          = regwe_q;
    assign Rw             = rw_q;
    assign Din            = din_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus randomized traffic against a queue-based write model.
module tb_writeback_stage;
    localparam int DW = 32;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          regwe;
    logic [AW-1:0] Rw;
    logic [DW-1:0] Din;
    logic          dbl_pending;

    writeback_stage_if #(.DW(DW), .AW(AW)) bus ();

    writeback_stage #(.DW(DW), .AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_if       (bus),
        .regwe       (regwe),
        .Rw          (Rw),
        .Din         (Din),
        .dbl_pending (dbl_pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] d;
    } wr_t;

    int  n_chk  = 0;
    int  n_fail = 0;
    wr_t q[$];
    wr_t cur;
    bit  cur_we = 1'b0;
    int  we_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference load extraction using shifts/masks on the numeric high word.
    function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] sz,
                                             input logic sg, input logic [1:0] off);
        logic [31:0] v;
        int          nb;
        case (sz)
            2'b00: begin nb = 8;  v = (w >> (8 * (3 - int'(off)))) & 32'hFF; end
            2'b01: begin nb = 16; v = (w >> (off[1] ? 0 : 16)) & 32'hFFFF; end
            default: begin nb = 32; v = w; end
        endcase
        if (sg && nb < 32 && v[nb-1]) v = v | (32'hFFFF_FFFF << nb);
        return v;
    endfunction

    // One clock: model consumes the transfer at the edge, then outputs are checked at the falling edge.
    task automatic cycle(output bit acc);
        logic [63:0] data;
        logic        exp_we;
        @(posedge clk);
        acc  = 1'b0;
        data = bus.in_data;
        if (bus.in_valid && q.size() == 0) begin
            acc = 1'b1;
            if (bus.in_load)
                q.push_back('{bus.in_rd, load_val(data[63:32], bus.in_ldsize, bus.in_ldsigned, bus.in_byteoff)});
            else if (bus.in_dbl) begin
                q.push_back('{bus.in_rd & ~6'd1, data[63:32]});
                q.push_back('{bus.in_rd | 6'd1, data[31:0]});
            end else
                q.push_back('{bus.in_rd, data[63:32]});
        end
        if (q.size() > 0) begin
            cur    = q.pop_front();
            cur_we = 1'b1;
        end else
            cur_we = 1'b0;
        @(negedge clk);
        exp_we = cur_we;
`ifdef WB_R0_PROTECT_EN
        if (cur_we && cur.rd == '0) exp_we = 1'b0;
`endif
        check("regwe", regwe, exp_we);
        if (exp_we) begin
            check("Rw", Rw, cur.rd);
            check("Din", Din, cur.d);
            we_cnt++;
        end
        check("in_ready", bus.in_ready, q.size() == 0);
        check("dbl_pending", dbl_pending, q.size() != 0);
    endtask

    task automatic send(input logic [AW-1:0] rd, input logic [63:0] data, input logic dbl,
                        input logic ld, input logic [1:0] sz, input logic sg, input logic [1:0] off);
        bit acc;
        bus.in_valid    = 1'b1;
        bus.in_rd       = rd;
        bus.in_data     = data;
        bus.in_dbl      = dbl;
        bus.in_load     = ld;
        bus.in_ldsize   = sz;
        bus.in_ldsigned = sg;
        bus.in_byteoff  = off;
        for (int i = 0; i < 8; i++) begin
            cycle(acc);
            if (acc) return;
        end
        check("accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        bit acc;
        bus.in_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle(acc);
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_rd       = '0;
        bus.in_data     = '0;
        bus.in_dbl      = 1'b0;
        bus.in_load     = 1'b0;
        bus.in_ldsize   = 2'b00;
        bus.in_ldsigned = 1'b0;
        bus.in_byteoff  = 2'b00;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_regwe", regwe, 1'b0);
        check("rst_Rw", Rw, '0);
        check("rst_Din", Din, '0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_dbl_pending", dbl_pending, 1'b0);
        reset = 1'b0;
        idle(2);

        // Reset while the second half of a double is still outstanding.
        send(6'd10, 64'h11112222_33334444, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
        check("mid_dbl_pending", dbl_pending, 1'b1);
        bus.in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_regwe", regwe, 1'b0);
        check("mid_rst_in_ready", bus.in_ready, 1'b1);
        check("mid_rst_dbl_pending", dbl_pending, 1'b0);
        q.delete();
        cur_we = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("no_r11_write", regwe && (Rw == 6'd11), 1'b0);
        end

        // Single write then idle.
        send(6'd5, 64'hDEADBEEF_01234567, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
        check("single_Rw", Rw, 6'd5);
        check("single_Din", Din, 32'hDEADBEEF);
        idle(1);
        check("single_after_regwe", regwe, 1'b0);

        // Two back-to-back doubles with valid held: four contiguous writes.
        we_cnt = 0;
        send(6'd7, 64'hAAAA0001_BBBB0002, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
        check("dbl_Rw0", Rw, 6'd6);
        check("dbl_Din0", Din, 32'hAAAA0001);
        check("dbl_in_ready", bus.in_ready, 1'b0);
        send(6'd12, 64'hCCCC0003_DDDD0004, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
        check("dbl2_Rw0", Rw, 6'd12);
        idle(2);
        check("dbl_gapless", we_cnt, 4);

        // Load extraction on high word 0x80F17F22.
        send(6'd3, 64'h80F17F22_5A5A5A5A, 1'b0, 1'b1, 2'b00, 1'b1, 2'd1);
        check("ld_b1_s", Din, 32'hFFFFFFF1);
        send(6'd3, 64'h80F17F22_5A5A5A5A, 1'b0, 1'b1, 2'b00, 1'b0, 2'd2);
        check("ld_b2_u", Din, 32'h0000007F);
        send(6'd3, 64'h80F17F22_5A5A5A5A, 1'b0, 1'b1, 2'b01, 1'b1, 2'd2);
        check("ld_h2_s", Din, 32'h00007F22);
        send(6'd3, 64'h80F17F22_5A5A5A5A, 1'b1, 1'b1, 2'b01, 1'b1, 2'd0);
        check("ld_h0_s", Din, 32'hFFFF80F1);
        send(6'd3, 64'h80F17F22_5A5A5A5A, 1'b0, 1'b1, 2'b11, 1'b1, 2'd3);
        check("ld_w11", Din, 32'h80F17F22);
        idle(1);

        // Continuous stream of singles.
        we_cnt = 0;
        for (int r = 1; r <= 8; r++)
            send(AW'(r), {32'(r * 32'h01010101), 32'h0}, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
        idle(1);
        check("stream_writes", we_cnt, 8);

        // Register-0 targets (suppressed only when the protection is built in).
        send(6'd0, 64'h12345678_9ABCDEF0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
        send(6'd0, 64'h0BADF00D_FEEDFACE, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
        idle(2);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0)
                idle(1);
            else
                send(AW'($urandom), {32'($urandom), 32'($urandom)}, 1'($urandom), 1'($urandom_range(0, 2) == 0),
                     2'($urandom), 1'($urandom), 2'($urandom));
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
